game_btn_arbiter: RTL
=====================

# game_btn_arbiter

Front-end conditioner for the two-player score game. It synchronizes and debounces the three active-low push buttons (BtnA, BtnB, clear) and enforces mutual lockout between players. It emits clean single-cycle increment and clear pulses that drive the per-player 7-segment score counters downstream. It is the producing end of the button-to-score-counter interface: the counters see only qualified, edge-derived events, never raw button levels.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable samples required before a debounced level changes; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width, derived; not overridden.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- BtnA  input  1  player A button, raw, active-low, asynchronous to clk.
- BtnB  input  1  player B button, raw, active-low, asynchronous to clk.
- clear  input  1  clear button, raw, active-low, asynchronous to clk.
- inc_a  output  1  one-cycle pulse: increment score A.
- inc_b  output  1  one-cycle pulse: increment score B.
- clr  output  1  one-cycle pulse: clear both scores.
- owner  output  2  lockout state: 00 none, 01 A holds, 10 B holds; 11 never driven.

## Operation
- Reset values:
  - sync flops and debounced levels = 1 (released).
  - debounce counters = 0.
  - FSM = IDLE.
  - inc_a, inc_b, clr = 0.
  - owner = 00.
- Per button, with s the synchronized sample and db the debounced level:
  - s == db: counter cleared.
  - s != db: counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and s != db: db <= s, counter <= 0.
  - Any bounce back to db before that point restarts the count from 0.
- Press event: db transitions 1 -> 0. Release event: db transitions 0 -> 1.
- FSM states: IDLE, HOLD_A, HOLD_B.
  - IDLE, A press: inc_a pulse, go to HOLD_A.
  - IDLE, B press, no A press in the same cycle: inc_b pulse, go to HOLD_B.
  - IDLE, A and B press in the same cycle: A wins. inc_a only, go to HOLD_A. The B press is discarded.
  - HOLD_A: B press/release ignored. A release returns to IDLE.
  - HOLD_B: mirror of HOLD_A.
- A button still held when the other player releases produces no pulse. A new press event is required.
- A button held through reset deassertion is seen as a press after debounce and is counted.
- Clear:
  - clr pulses on each clear press event.
  - Independent of the FSM: clear does not change owner and is never locked out.
  - clr may coincide with inc_a/inc_b. The downstream counter gives clear priority.
- Release events never generate pulses. At most one pulse per press.

## Timing
- Raw low first sampled at edge 1 and held stable: pulse is registered at edge DEBOUNCE_CYCLES+2 and is high for exactly one cycle.
- owner updates on the same edge as the pulse.
- Release latency back to IDLE: same as press latency, DEBOUNCE_CYCLES+2 edges.
- A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no event.
- Pulses are registered outputs; no combinational path from inputs to outputs.
- rst_n assertion mid-operation:
  - Outputs clear immediately (asynchronously), including a pulse in flight.
  - FSM returns to IDLE; no pulse is generated on reset release.

## Configuration
- GAME_BTN_SYNC_EN defined: each raw input passes through a two-flop synchronizer before the debouncer. Latency is DEBOUNCE_CYCLES+2 edges.
- GAME_BTN_SYNC_EN undefined: a single input register replaces the synchronizer. Latency is DEBOUNCE_CYCLES+1 edges; all test expectations shift by -1.
  - For use only when inputs are already synchronous to clk.

## Structure
- Shared package game_pkg:
  - FSM state enum (IDLE, HOLD_A, HOLD_B).
  - owner encoding constants (OWNER_NONE, OWNER_A, OWNER_B).
- Sub-module game_btn_debounce: synchronizer (or single register) + debounce counter + press/release edge outputs, parameterized by DEBOUNCE_CYCLES.
  - Instantiated three times.
  - The arbiter FSM and the clr path live in the top.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 with GAME_BTN_SYNC_EN defined.
- Clean press: BtnA low from edge 1, held 20 cycles -> inc_a high only after edge 6; owner 01 from edge 6. Release -> owner 00 six edges after release; no second pulse.
- Bounce: BtnA low 3 cycles, high 1, low 3, then high -> no inc_a, owner stays 00. Then hold low 10 cycles -> exactly one inc_a.
- Lockout: A held (owner 01); BtnB pressed 10 cycles and released; then A released -> zero inc_b pulses, owner 01 -> 00.
- Simultaneous: BtnA and BtnB low on the same edge, held -> single inc_a, no inc_b, owner 01. A released while B held -> owner 00, still no inc_b.
- Clear during hold: owner 01, clear low 10 cycles -> one clr pulse, owner remains 01, no inc pulses.
- Reset mid-hold: owner 01, rst_n low for 2 cycles while BtnA stays low -> owner 00 and outputs 0 immediately. After release, one inc_a at edge 6 counted from reset release.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types for the two-player score game button front end.
// Holds the arbiter FSM state enum and the owner output encoding.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD_A = 2'b01,
        HOLD_B = 2'b10
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    function automatic logic [1:0] owner_of(input arb_state_t st);
        logic [1:0] o;
        case (st)
            HOLD_A:  o = OWNER_A;
            HOLD_B:  o = OWNER_B;
            default: o = OWNER_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/game_btn_debounce.sv
// game_btn_debounce: input capture + debounce counter for one active-low button.
// Ports: clk, rst_n, raw (async, active-low) -> press / rel single-cycle strobes.
// GAME_BTN_SYNC_EN: two-flop synchronizer on raw; otherwise a single register.
module game_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press,
    output logic rel
);

    logic             s;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             hit;

`ifdef GAME_BTN_SYNC_EN
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            s    <= 1'b1;
        end else begin
            meta <= raw;
            s    <= meta;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= 1'b1;
        end else begin
            s <= raw;
        end
    end
`endif

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample;
    // the strobes fire combinationally so the top registers them on that edge.
    assign hit   = (s != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press = hit && level;
    assign rel   = hit && !level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (s == level) begin
            cnt   <= '0;
        end else if (hit) begin
            level <= s;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_btn_arbiter.sv
// game_btn_arbiter: debounces BtnA/BtnB/clear and arbitrates player lockout.
// Ports: clk, rst_n, BtnA, BtnB, clear -> inc_a, inc_b, clr pulses, owner.
// GAME_BTN_SYNC_EN selects two-flop input synchronizers in the debouncers.
module game_btn_arbiter
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BtnA,
    input  logic       BtnB,
    input  logic       clear,
    output logic       inc_a,
    output logic       inc_b,
    output logic       clr,
    output logic [1:0] owner
);

    logic a_press, a_rel;
    logic b_press, b_rel;
    logic c_press, c_rel_unused;

    game_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W(CNT_W)
    ) u_db_a (
        .clk(clk), .rst_n(rst_n), .raw(BtnA),
        .press(a_press), .rel(a_rel)
    );

    game_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W(CNT_W)
    ) u_db_b (
        .clk(clk), .rst_n(rst_n), .raw(BtnB),
        .press(b_press), .rel(b_rel)
    );

    game_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W(CNT_W)
    ) u_db_c (
        .clk(clk), .rst_n(rst_n), .raw(clear),
        .press(c_press), .rel(c_rel_unused)
    );

    arb_state_t state, state_nx;
    logic       inc_a_nx, inc_b_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            inc_a <= 1'b0;
            inc_b <= 1'b0;
            clr   <= 1'b0;
            owner <= OWNER_NONE;
        end else begin
            state <= state_nx;
            inc_a <= inc_a_nx;
            inc_b <= inc_b_nx;
            clr   <= c_press;
            owner <= owner_of(state_nx);
        end
    end

    // A wins a same-cycle tie; the holder's opponent is ignored entirely
    // until the holder releases, and then needs a fresh press.
    always_comb begin
        state_nx = state;
        inc_a_nx = 1'b0;
        inc_b_nx = 1'b0;
        case (state)
            IDLE: begin
                if (a_press) begin
                    inc_a_nx = 1'b1;
                    state_nx = HOLD_A;
                end else if (b_press) begin
                    inc_b_nx = 1'b1;
                    state_nx = HOLD_B;
                end
            end
            HOLD_A: begin
                if (a_rel) state_nx = IDLE;
            end
            HOLD_B: begin
                if (b_rel) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
